// File: rtl/pow2_lut_arb_pkg.sv
// Shared types and helpers for the Pow2LUT round-robin arbiter.
// Optional feature macro used by the top: POW2_LUT_ARB_STATS_EN.
package pow2_lut_arb_pkg;

   // Index width that never collapses to zero bits.
   function automatic int unsigned clog2_safe(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Pointer value after reset: last requester, so requester 0 wins first.
   function automatic int unsigned rr_rst_ptr(input int unsigned n);
      return n - 1;
   endfunction

   // Geometry of the shared LUT slice this arbiter serves.
   localparam int unsigned ARB_IN      = 4;
   localparam int unsigned ARB_OUT     = 5;
   localparam int unsigned ARB_NUM_REQ = 4;
   localparam int unsigned ARB_ID_W    = clog2_safe(ARB_NUM_REQ);

   // Stage-1 record: LUT operand plus the requester it came from.
   typedef struct packed {
      logic [ARB_IN-1:0]   operand;
      logic [ARB_ID_W-1:0] id;
   } s1_rec_t;

endpackage

// File: rtl/Pow2LUT.sv
// Pow2LUT: fraction table for 2^x, x in [0,1) with 4 fraction bits.
// result = round((2^(operand/16) - 1) * 32), i.e. the fractional part of 2^x in 5 bits.
module Pow2LUT #(
   parameter int unsigned IN  = 4,
   parameter int unsigned OUT = 5
) (
   input  logic [IN-1:0]  operand,
   output logic [OUT-1:0] result
);

   // Pure lookup, no state.
   always_comb begin
      result = '0;
      case (operand)
         4'd0:    result = OUT'(5'd0);
         4'd1:    result = OUT'(5'd1);
         4'd2:    result = OUT'(5'd3);
         4'd3:    result = OUT'(5'd4);
         4'd4:    result = OUT'(5'd6);
         4'd5:    result = OUT'(5'd8);
         4'd6:    result = OUT'(5'd9);
         4'd7:    result = OUT'(5'd11);
         4'd8:    result = OUT'(5'd13);
         4'd9:    result = OUT'(5'd15);
         4'd10:   result = OUT'(5'd17);
         4'd11:   result = OUT'(5'd20);
         4'd12:   result = OUT'(5'd22);
         4'd13:   result = OUT'(5'd24);
         4'd14:   result = OUT'(5'd27);
         4'd15:   result = OUT'(5'd29);
         default: result = '0;
      endcase
   end

endmodule

// File: rtl/pow2_lut_arbiter_rr_picker.sv
// rr_picker: combinational round-robin search starting just after ptr, wrapping.
module rr_picker #(
   parameter int unsigned N   = 4,
   parameter int unsigned IDW = 2
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [N-1:0]   gnt,
   output logic [IDW-1:0] idx
);

   // First requester at ptr+1, ptr+2, ... modulo N wins.
   always_comb begin
      int unsigned j;
      logic        found;
      gnt   = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int unsigned k = 1; k <= N; k++) begin
         j = (int'(ptr) + k) % N;
         if (!found && req[j]) begin
            found  = 1'b1;
            gnt[j] = 1'b1;
            idx    = IDW'(j);
         end
      end
   end

endmodule

// File: rtl/pow2_lut_arbiter.sv
// pow2_lut_arbiter: round-robin sharing of one Pow2LUT among NUM_REQ requesters.
// Two stages: operand/id register, then LUT into the output register.
// Define POW2_LUT_ARB_STATS_EN to add per-requester saturating grant counters.
module pow2_lut_arbiter
   import pow2_lut_arb_pkg::*;
#(
   parameter int unsigned IN      = 4,
   parameter int unsigned OUT     = 5,
   parameter int unsigned NUM_REQ = 4
) (
   input  logic                                 clock,
   input  logic                                 resetn,
   input  logic [NUM_REQ-1:0]                   in_valid,
   output logic [NUM_REQ-1:0]                   in_ready,
   input  logic [NUM_REQ-1:0][IN-1:0]           in_data,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [OUT-1:0]                       out_data,
`ifdef POW2_LUT_ARB_STATS_EN
   output logic [NUM_REQ-1:0][15:0]             grant_count,
`endif
   output logic [clog2_safe(NUM_REQ)-1:0]       out_id
);

   localparam int unsigned IDW = clog2_safe(NUM_REQ);
   localparam logic [IDW-1:0] RST_PTR = IDW'(rr_rst_ptr(NUM_REQ));

   // The stage-1 record type is sized by the package geometry.
   if (IN != ARB_IN || NUM_REQ != ARB_NUM_REQ || NUM_REQ < 2) begin : g_bad_cfg
      $error("pow2_lut_arbiter: parameters do not match pow2_lut_arb_pkg geometry");
   end

   logic [IDW-1:0]     ptr_q;
   s1_rec_t            s1_q;
   logic               s1_valid_q;
   logic               advance;
   logic               s1_load;
   logic               xfer;
   logic [NUM_REQ-1:0] pick_gnt;
   logic [IDW-1:0]     pick_idx;
   logic [OUT-1:0]     lut_out;

   rr_picker #(
      .N   (NUM_REQ),
      .IDW (IDW)
   ) u_picker (
      .req (in_valid),
      .ptr (ptr_q),
      .gnt (pick_gnt),
      .idx (pick_idx)
   );

   Pow2LUT #(
      .IN  (IN),
      .OUT (OUT)
   ) u_lut (
      .operand (s1_q.operand),
      .result  (lut_out)
   );

   // Handshake: grant only when stage 1 can take a new operand; silent in reset.
   always_comb begin
      advance  = !out_valid || out_ready;
      s1_load  = !s1_valid_q || advance;
      in_ready = (resetn && s1_load) ? pick_gnt : '0;
      xfer     = |(in_valid & in_ready);
   end

   // Stage 1 and round-robin pointer.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         s1_valid_q <= 1'b0;
         s1_q       <= '0;
         ptr_q      <= RST_PTR;
      end else begin
         if (s1_load) begin
            s1_valid_q <= xfer;
         end
         if (xfer) begin
            s1_q.operand <= in_data[pick_idx];
            s1_q.id      <= pick_idx;
            ptr_q        <= pick_idx;
         end
      end
   end

   // Output register: LUT result moves out whenever the consumer side can advance.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_id    <= '0;
      end else if (advance) begin
         out_valid <= s1_valid_q;
         if (s1_valid_q) begin
            out_data <= lut_out;
            out_id   <= s1_q.id;
         end
      end
   end

`ifdef POW2_LUT_ARB_STATS_EN
   // Per-requester accepted-transfer counters, saturating.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         grant_count <= '0;
      end else begin
         for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (in_valid[i] && in_ready[i] && grant_count[i] != 16'hFFFF) begin
               grant_count[i] <= grant_count[i] + 16'd1;
            end
         end
      end
   end
`endif

endmodule

// File: tb/tb_pow2_lut_arbiter.sv
// Directed self-checking bench for pow2_lut_arbiter (IN=4, OUT=5, NUM_REQ=4).
// Golden LUT values are computed from 2^x arithmetic, not from a table.
module tb_pow2_lut_arbiter;

   logic            clock;
   logic            resetn;
   logic [3:0]      in_valid;
   logic [3:0]      in_ready;
   logic [3:0][3:0] in_data;
   logic            out_valid;
   logic            out_ready;
   logic [4:0]      out_data;
   logic [1:0]      out_id;
`ifdef POW2_LUT_ARB_STATS_EN
   logic [3:0][15:0] grant_count;
`endif

   int passed = 0;
   int total  = 0;

   pow2_lut_arbiter #(
      .IN      (4),
      .OUT     (5),
      .NUM_REQ (4)
   ) dut (
      .clock       (clock),
      .resetn      (resetn),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
`ifdef POW2_LUT_ARB_STATS_EN
      .grant_count (grant_count),
`endif
      .out_id      (out_id)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [4:0] golden(input logic [3:0] x);
      real r;
      r = (2.0 ** (real'(x) / 16.0) - 1.0) * 32.0;
      return 5'($rtoi(r + 0.5));
   endfunction

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      resetn    = 1'b0;
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      step();
      step();
      total++;
      if (out_valid !== 1'b0 || out_data !== 5'd0 || out_id !== 2'd0)
         $display("FAIL reset_outputs: got v=%b d=%0d id=%0d want v=0 d=0 id=0",
                  out_valid, out_data, out_id);
      else passed++;
      total++;
      if (in_ready !== 4'b0000)
         $display("FAIL reset_in_ready: got %b want 0000", in_ready);
      else passed++;
      in_valid = 4'b0000;
      resetn   = 1'b1;
   endtask

   task automatic test_reset();
      apply_reset();
      total++;
      if (in_ready !== 4'b0000)
         $display("FAIL idle_in_ready: got %b want 0000", in_ready);
      else passed++;
   endtask

   task automatic test_single();
      in_data[0] = 4'd0;
      in_valid   = 4'b0001;
      out_ready  = 1'b1;
      #1;
      total++;
      if (in_ready !== 4'b0001) $display("FAIL single_grant: got %b want 0001", in_ready);
      else passed++;
      step();
      in_valid = 4'b0000;
      total++;
      if (out_valid !== 1'b0) $display("FAIL single_latency: got v=%b want 0", out_valid);
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || out_data !== 5'd0 || out_id !== 2'd0)
         $display("FAIL single_result: got v=%b d=%0d id=%0d want v=1 d=0 id=0",
                  out_valid, out_data, out_id);
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL single_drain: got v=%b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_round_robin();
      logic [1:0] eid;
      apply_reset();
      in_data   = {4'd15, 4'd11, 4'd8, 4'd3};
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         total++;
         if (in_ready !== 4'(1 << (c % 4)))
            $display("FAIL rr_grant[%0d]: got %b want %b", c, in_ready, 4'(1 << (c % 4)));
         else passed++;
         step();
         if (c >= 1) begin
            eid = 2'((c - 1) % 4);
            total++;
            if (out_valid !== 1'b1 || out_id !== eid || out_data !== golden(in_data[eid]))
               $display("FAIL rr_result[%0d]: got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d",
                        c, out_valid, out_id, out_data, eid, golden(in_data[eid]));
            else passed++;
         end
      end
      in_valid = 4'b0000;
      step();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd3 || out_data !== golden(4'd15))
         $display("FAIL rr_last: got v=%b id=%0d d=%0d want v=1 id=3 d=%0d",
                  out_valid, out_id, out_data, golden(4'd15));
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL rr_drain: got v=%b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_backpressure();
      int xfers;
      apply_reset();
      in_data   = {4'd13, 4'd9, 4'd5, 4'd2};
      in_valid  = 4'b1111;
      out_ready = 1'b0;
      xfers     = 0;
      #1;
      for (int c = 0; c < 5; c++) begin
         xfers += $countones(in_valid & in_ready);
         if (c >= 2) begin
            total++;
            if (in_ready !== 4'b0000 || out_id !== 2'd0 || out_data !== golden(4'd2))
               $display("FAIL bp_stall[%0d]: got rdy=%b id=%0d d=%0d want rdy=0000 id=0 d=%0d",
                        c, in_ready, out_id, out_data, golden(4'd2));
            else passed++;
         end
         step();
      end
      total++;
      if (xfers !== 2) $display("FAIL bp_xfers: got %0d want 2", xfers);
      else passed++;
      out_ready = 1'b1;
      #1;
      total++;
      if (in_ready !== 4'b0100) $display("FAIL bp_release_grant: got %b want 0100", in_ready);
      else passed++;
      step();
      in_valid = 4'b0000;
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd1 || out_data !== golden(4'd5))
         $display("FAIL bp_out1: got v=%b id=%0d d=%0d want v=1 id=1 d=%0d",
                  out_valid, out_id, out_data, golden(4'd5));
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd2 || out_data !== golden(4'd9))
         $display("FAIL bp_out2: got v=%b id=%0d d=%0d want v=1 id=2 d=%0d",
                  out_valid, out_id, out_data, golden(4'd9));
      else passed++;
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL bp_drain: got v=%b want 0", out_valid);
      else passed++;
   endtask

   task automatic test_wrap();
      apply_reset();
      out_ready = 1'b1;
      in_valid  = 4'b1001;
      #1;
      total++;
      if (in_ready !== 4'b0001) $display("FAIL wrap_ptr3: got %b want 0001", in_ready);
      else passed++;
      step();
      total++;
      if (in_ready !== 4'b1000) $display("FAIL wrap_ptr0: got %b want 1000", in_ready);
      else passed++;
      step();
      total++;
      if (in_ready !== 4'b0001) $display("FAIL wrap_again: got %b want 0001", in_ready);
      else passed++;
      in_valid = 4'b0000;
      #1;
      total++;
      if (in_ready !== 4'b0000) $display("FAIL wrap_none: got %b want 0000", in_ready);
      else passed++;
      step();
      step();
   endtask

   task automatic test_reset_midstream();
      in_data   = {4'd7, 4'd6, 4'd4, 4'd1};
      in_valid  = 4'b1111;
      out_ready = 1'b1;
      step();
      step();
      total++;
      if (out_valid !== 1'b1) $display("FAIL mid_pre: got v=%b want 1", out_valid);
      else passed++;
      resetn = 1'b0;
      #1;
      total++;
      if (out_valid !== 1'b0 || in_ready !== 4'b0000)
         $display("FAIL mid_async: got v=%b rdy=%b want v=0 rdy=0000", out_valid, in_ready);
      else passed++;
      step();
      in_valid = 4'b0000;
      resetn   = 1'b1;
      step();
      total++;
      if (out_valid !== 1'b0) $display("FAIL mid_no_output: got v=%b want 0", out_valid);
      else passed++;
      in_valid = 4'b1111;
      #1;
      total++;
      if (in_ready !== 4'b0001) $display("FAIL mid_first_grant: got %b want 0001", in_ready);
      else passed++;
      step();
      in_valid = 4'b0000;
      step();
      total++;
      if (out_valid !== 1'b1 || out_id !== 2'd0 || out_data !== golden(4'd1))
         $display("FAIL mid_result: got v=%b id=%0d d=%0d want v=1 id=0 d=%0d",
                  out_valid, out_id, out_data, golden(4'd1));
      else passed++;
      step();
   endtask

`ifdef POW2_LUT_ARB_STATS_EN
   task automatic test_stats();
      apply_reset();
      out_ready  = 1'b1;
      in_data[2] = 4'd10;
      in_valid   = 4'b0100;
      repeat (10) step();
      in_valid = 4'b0000;
      step();
      step();
      for (int i = 0; i < 4; i++) begin
         total++;
         if (grant_count[i] !== ((i == 2) ? 16'd10 : 16'd0))
            $display("FAIL stats_count[%0d]: got %0d want %0d", i, grant_count[i],
                     (i == 2) ? 10 : 0);
         else passed++;
      end
   endtask
`endif

   task automatic test_sweep();
      out_ready = 1'b1;
      for (int r = 0; r < 4; r++) begin
         for (int x = 0; x < 16; x++) begin
            in_data[r] = 4'(x);
            in_valid   = 4'(1 << r);
            step();
            in_valid = 4'b0000;
            step();
            total++;
            if (out_valid !== 1'b1 || out_id !== 2'(r) || out_data !== golden(4'(x)))
               $display("FAIL sweep[r%0d x%0d]: got v=%b id=%0d d=%0d want v=1 id=%0d d=%0d",
                        r, x, out_valid, out_id, out_data, r, golden(4'(x)));
            else passed++;
         end
      end
      step();
   endtask

   initial begin
      resetn    = 1'b0;
      in_valid  = 4'b0000;
      in_data   = '0;
      out_ready = 1'b0;
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_wrap();
      test_reset_midstream();
`ifdef POW2_LUT_ARB_STATS_EN
      test_stats();
`endif
      test_sweep();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
